// File: rtl/add_seq_ctrl.sv
// Word-serial multi-precision adder: one 32-bit carry-skip adder reused WORDS times, LSW first.
// Optional subtraction (A-B) is enabled by defining ADD_SEQ_SUB_EN.
module carry_skip4_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    logic       blk_c;
    logic       rip_c;
    logic [3:0] prop;

    // 4-bit ripple blocks; a fully propagating block forwards its carry-in directly
    always_comb begin
        s     = '0;
        blk_c = cin;
        rip_c = 1'b0;
        prop  = '0;
        for (int g = 0; g < 8; g++) begin
            rip_c = blk_c;
            for (int k = 0; k < 4; k++) begin
                prop[k]     = a[4*g+k] ^ b[4*g+k];
                s[4*g+k]    = prop[k] ^ rip_c;
                rip_c       = (a[4*g+k] & b[4*g+k]) | (prop[k] & rip_c);
            end
            blk_c = (&prop) ? blk_c : rip_c;
        end
        cout = blk_c;
    end
endmodule

module add_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    if (WIDTH != 32) begin : g_bad_width
        $error("add_seq_ctrl: WIDTH must equal the 32-bit adder width");
    end
    if (WORDS < 2 || WORDS > 16) begin : g_bad_words
        $error("add_seq_ctrl: WORDS must be in 2..16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         state_q, state_d;
    logic   [IDX_W-1:0]             idx_q;
    logic                           carry_q;
    logic   [WORDS-1:0][WIDTH-1:0]  a_q, b_q, sum_w;
    logic                           accept;
    logic                           cin_eff;
    logic   [WIDTH-1:0]             a_word, b_eff, s_word;
    logic                           c_word;

    assign sum = sum_w;

`ifdef ADD_SEQ_SUB_EN
    logic sub_q;
    assign cin_eff = sub ? 1'b1 : cin;
    assign b_eff   = sub_q ? ~b_q[idx_q] : b_q[idx_q];
`else
    assign cin_eff = cin;
    assign b_eff   = b_q[idx_q];
`endif
    assign a_word = a_q[idx_q];

    carry_skip4_32bits u_add (
        .a    (a_word),
        .b    (b_eff),
        .cin  (carry_q),
        .s    (s_word),
        .cout (c_word)
    );

    // Operand capture: data only, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
`ifdef ADD_SEQ_SUB_EN
            sub_q <= sub;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_w   <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q   <= '0;
                        carry_q <= cin_eff;
                    end
                end
                RUN: begin
                    sum_w[idx_q] <= s_word;
                    carry_q      <= c_word;
                    idx_q        <= idx_q + IDX_W'(1);
                    if (idx_q == LAST) begin
                        idx_q <= '0;
                        cout  <= c_word;
                        ovf   <= (a_word[WIDTH-1] == b_eff[WIDTH-1]) &&
                                 (s_word[WIDTH-1] != a_word[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            RUN:     busy = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
        accept = in_valid && in_ready;
    end
endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
- Sequencer that time-multiplexes one 32-bit carry-skip adder (carry_skip4_32bits) to perform a WORDS×32-bit multi-precision addition, one word per clock, LSW first.
- The inter-word carry is registered between cycles.
- Valid/ready handshake on both input and output.
- Sits between operand producers (accumulators, MAC tails) and the wide-result consumer; trades latency for area versus a full-width adder.

Parameters:
- WIDTH, 32, adder word width; fixed to the instantiated adder width, any other value is a configuration error.
- WORDS, 4, number of words per operand (total operand width WIDTH*WORDS); legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH*WORDS  operand A
- b  input  WIDTH*WORDS  operand B
- cin  input  1  carry-in to LSW
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH*WORDS  result
- cout  output  1  carry-out of MSW
- ovf  output  1  signed overflow of full-width result
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: asynchronous and active-low; clock is single rising-edge clk.
- Reset values:
  - State = IDLE, word index = 0, carry register = 0.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0, busy = 0.
  - in_ready = 1 after reset deassertion.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready: register a, b, cin; carry reg <= cin; idx <= 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, the adder gets A word idx, B word idx and the carry reg.
  - Adder S is written into sum word idx; carry reg <= adder Cout; idx <= idx+1.
  - When idx = WORDS-1, the word is written, cout <= adder Cout, ovf is computed, and the FSM goes to DONE.
- ovf = (A_msb == B_eff_msb) && (S_msb != A_msb), evaluated on the MSW cycle.
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable.
  - in_valid is ignored.
  - On out_ready, go to IDLE and drop out_valid the next cycle.
- Latency: out_valid rises exactly WORDS cycles after the accepting edge.
- Throughput: one operation per WORDS+2 cycles when out_ready is held high (accept, WORDS run cycles, DONE handshake, return to IDLE).
- sum words not yet written during RUN hold their previous-result values; consumers sample only when out_valid = 1.
- Captured operands are unaffected by changes on a/b/cin after acceptance.
- Reset mid-operation (RUN or DONE): immediate abort; all outputs return to reset values; partial result is discarded.
- Arithmetic is modulo 2^(WIDTH*WORDS); cout is the true carry-out of the wide sum.

Optional Feature:
- Macro: ADD_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub = 1: B words are bitwise inverted before the adder, LSW carry-in is forced to 1 (cin ignored), and the result is A-B.
  - cout = 1 means no borrow.
  - ovf uses the inverted B MSB.
- Not defined:
  - No sub port; addition only.
  - B is never inverted; carry-in is always cin.

Test Plan:
- WORDS=4: a = all ones (128'hFFFF…F), b = 1, cin = 0 → out_valid exactly 4 cycles after accept; sum = 0; cout = 1; ovf = 0.
- Carry across word boundary: a = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, b = 1 → sum = 128'h…0001_0000_0000; cout = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid while in_valid = 1 with new operands → sum/cout stable; in_ready = 0; new operands not taken. Raise out_ready → IDLE, then new operands accepted.
- Overflow: a = 128'h7FFF…F, b = 1 → sum = 128'h8000…0; ovf = 1; cout = 0.
- Reset mid-operation: assert rst_n = 0 asynchronously on the 2nd RUN cycle → outputs zero immediately. After release in_ready = 1, and a fresh 3+4 operation gives sum = 7.
- ADD_SEQ_SUB_EN defined: a = 5, b = 7, sub = 1 → sum = 2^128-2 (128'hFFFF…FFFE); cout = 0; ovf = 0. Repeat with a = 7, b = 5 → sum = 2; cout = 1.
